// File: rtl/rv32_fetch_queue_if.sv
// Fetch/decode handshake bundle for the rv32 fetch queue.
// The master side is fetch+decode, the slave side is the queue itself.
interface rv32_fetch_queue_if #(parameter int XLEN = 32);
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [31:0]     enq_instr_i;
  logic [XLEN-1:0] enq_pc_i;
  logic            enq_fault_i;
  logic            deq_valid_o;
  logic            deq_ready_i;
  logic [31:0]     deq_instr_o;
  logic [XLEN-1:0] deq_pc_o;
  logic            deq_exc_o;
  logic [3:0]      deq_cause_o;

  modport master (
    output enq_valid_i, enq_instr_i, enq_pc_i, enq_fault_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_instr_o, deq_pc_o, deq_exc_o, deq_cause_o
  );

  modport slave (
    input  enq_valid_i, enq_instr_i, enq_pc_i, enq_fault_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_instr_o, deq_pc_o, deq_exc_o, deq_cause_o
  );
endinterface

// File: rtl/rv32_fetch_queue.sv
// DEPTH-entry first-word-fall-through IF/ID buffer with flush, optional
// zero-latency bypass and per-entry fetch exception tagging.
module rv32_fetch_queue #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 4,
  parameter int          BYPASS    = 0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  rv32_fetch_queue_if.slave          q,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  entry_t          enq_e, head;
  logic            empty, full, byp, enq_fire, deq_fire, wr_en, rd_adv, misal;

  // Extra pointer MSB is a wrap bit so full and empty are distinguishable.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  assign enq_e = '{fault: q.enq_fault_i, pc: q.enq_pc_i, instr: q.enq_instr_i};

  assign q.enq_ready_o = !full && !rst;

  assign byp  = (BYPASS != 0) && empty && q.enq_valid_i && !flush_i && !rst;
  assign head = byp ? enq_e : mem[rd_ptr[AW-1:0]];

  assign q.deq_valid_o = (!empty || byp) && !flush_i && !rst;

  assign enq_fire = q.enq_valid_i && q.enq_ready_o && !flush_i;
  assign deq_fire = q.deq_valid_o && q.deq_ready_i;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en  = enq_fire && !(byp && q.deq_ready_i);
  assign rd_adv = deq_fire && !byp;

  assign misal         = (head.pc[1:0] != 2'b00);
  assign q.deq_instr_o = q.deq_valid_o ? head.instr : NOP_INSTR;
  assign q.deq_pc_o    = q.deq_valid_o ? head.pc : '0;
  assign q.deq_exc_o   = q.deq_valid_o && (head.fault || misal);
  // Access fault outranks misalignment; misalignment cause code is 0.
  assign q.deq_cause_o = (q.deq_valid_o && head.fault) ? 4'h1 : 4'h0;

  assign count_o = CW'(wr_ptr - rd_ptr);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= enq_e;
  end
endmodule
